// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the sipo_deser serial-to-parallel deserialiser.
package sipo_pkg;

  localparam logic PARITY_EVEN = 1'b0;

  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and word-completion strobe; SIPO_PARITY_EN adds a trailing even-parity bit.
// Strobe is combinational in the cycle the last bit is sampled; no backpressure, the caller registers it.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic             word_vld,
  output logic [WIDTH-1:0] word_dat,
  output logic             word_perr
);

`ifdef SIPO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int            CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             at_last;

  always_comb begin
    sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], serial_in}
                                  : {serial_in, sr_q[WIDTH-1:1]};
    at_last    = bit_valid && !frame_start && (cnt_q == CNT_LAST);
    word_vld   = at_last;
    cnt_d      = cnt_q;
    if (bit_valid) begin
      if (frame_start)             cnt_d = CW'(1);
      else if (cnt_q == CNT_LAST)  cnt_d = '0;
      else                         cnt_d = cnt_q + CW'(1);
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_q, par_d;

  // The parity bit is consumed by the checker, never shifted, so the word is sr as it stands.
  always_comb begin
    sr_d      = sr_q;
    par_d     = par_q;
    word_dat  = sr_q;
    word_perr = at_last && ((par_q ^ serial_in) != PARITY_EVEN);
    if (bit_valid && !at_last) begin
      sr_d = sr_shifted;
      if (frame_start || cnt_q == '0) par_d = serial_in;
      else                            par_d = par_q ^ serial_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`else
  always_comb begin
    sr_d      = bit_valid ? sr_shifted : sr_q;
    word_dat  = sr_shifted;
    word_perr = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserialiser top (optional SIPO_PARITY_EN): word register with valid/ready and sticky overflow.
// Word appears 1 cycle after its last bit; a word completing while the holder is full and not ready is dropped.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             parity_err
);

  logic             word_vld, word_perr, load;
  logic [WIDTH-1:0] word_dat;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overflow_q, overflow_d;
  logic             parity_err_q, parity_err_d;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .word_vld    (word_vld),
    .word_dat    (word_dat),
    .word_perr   (word_perr)
  );

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overflow_d   = overflow_q;
    parity_err_d = 1'b0;
    load         = word_vld && (!data_valid_q || data_ready);
    if (data_valid_q && data_ready) data_valid_d = 1'b0;
    if (ovf_clr)                    overflow_d   = 1'b0;
    // A drop in the same cycle as a clear leaves overflow set.
    if (load) begin
      data_out_d   = word_dat;
      data_valid_d = 1'b1;
      parity_err_d = word_perr;
    end else if (word_vld) begin
      overflow_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Two 8-bit deserialisers (MSB-first and LSB-first) driven by shared stimulus and checked against a bit-queue model.
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 9 : 8;

  logic       clk = 1'b0;
  logic       rst, serial_in, bit_valid, frame_start, data_ready, ovf_clr;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, ovf_m, ovf_l, perr_m, perr_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_m), .data_valid(valid_m),
    .data_ready(data_ready), .overflow(ovf_m), .ovf_clr(ovf_clr), .parity_err(perr_m)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_l), .data_valid(valid_l),
    .data_ready(data_ready), .overflow(ovf_l), .ovf_clr(ovf_clr), .parity_err(perr_l)
  );

  // Reference model: received bits of the current word in arrival order, plus the output holder.
  logic       bits_q[$];
  logic       exp_vld = 1'b0, exp_ovf = 1'b0, exp_perr = 1'b0;
  logic [7:0] exp_m = 8'h00, exp_l = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, bv, si, fs, rdy, clr);
    logic       done, pe;
    logic [7:0] wm, wl;
    done = 1'b0; pe = 1'b0; wm = 8'h00; wl = 8'h00;
    if (!r) begin
      bits_q.delete();
      exp_vld = 1'b0; exp_m = 8'h00; exp_l = 8'h00; exp_ovf = 1'b0; exp_perr = 1'b0;
    end else begin
      if (bv) begin
        if (fs) bits_q.delete();
        bits_q.push_back(si);
        if (bits_q.size() == NB) begin
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = bits_q[i];
            wl[i]   = bits_q[i];
          end
          if (PAR) for (int i = 0; i < NB; i++) pe = pe ^ bits_q[i];
          done = 1'b1;
          bits_q.delete();
        end
      end
      exp_perr = 1'b0;
      if (exp_vld && rdy) exp_vld = 1'b0;
      if (clr) exp_ovf = 1'b0;
      if (done) begin
        if (!exp_vld) begin
          exp_vld = 1'b1; exp_m = wm; exp_l = wl; exp_perr = pe;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic r, bv, si, fs, rdy, clr);
    rst = r; bit_valid = bv; serial_in = si; frame_start = fs;
    data_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_edge(r, bv, si, fs, rdy, clr);
    #1;
    chk("vld_m", valid_m, exp_vld);
    chk("vld_l", valid_l, exp_vld);
    chk("dat_m", dout_m, exp_m);
    chk("dat_l", dout_l, exp_l);
    chk("ovf_m", ovf_m, exp_ovf);
    chk("ovf_l", ovf_l, exp_ovf);
    chk("perr_m", perr_m, exp_perr);
    chk("perr_l", perr_l, exp_perr);
  endtask

  // Bits go out w[7] first; the parity bit (if any) follows, optionally corrupted.
  task automatic send_word(input logic [7:0] w, input logic fs, rdy, clr, bad);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, w[7-i], fs && (i == 0), rdy, clr);
    if (PAR) step(1'b1, 1'b1, (^w) ^ bad, 1'b0, rdy, clr);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_vld", valid_m, 1'b0);
    chk("rst_dat", dout_m, 8'h00);

    send_word(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("a5_vld", valid_m, 1'b1);
    chk("a5_dat", dout_m, 8'hA5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_one_cycle", valid_m, 1'b0);

    send_word(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lsb_48", dout_l, 8'h48);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_word(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_hold", dout_m, 8'h11);
    chk("ovf_set", ovf_m, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", ovf_m, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", ovf_m, 1'b1);
    chk("ovf_hold2", dout_m, 8'h11);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("drain_vld", valid_m, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("realign_3c", dout_m, 8'h3C);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_vld", valid_m, 1'b0);
    chk("mid_rst_dat", dout_m, 8'h00);
    send_word(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_c3", dout_m, 8'hC3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_word(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("par_bad", perr_m, PAR);
    chk("par_bad_dat", dout_m, 8'hA5);
    send_word(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_good", perr_m, 1'b0);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-to-parallel deserialiser, the next generation of the team's fixed 16-bit shift-in block. It samples a qualified serial stream on the rising edge of `clk` and assembles WIDTH-bit words, MSB-first or LSB-first. A frame-start input realigns word boundaries. Completed words are delivered through a valid/ready output register with sticky overflow detection. It sits between the serial front-end (ADC/sensor link) and the parallel processing datapath.

## Interface
- `WIDTH`, 16: word width in bits, 2..64.
- `MSB_FIRST`, 1: 1 = first received bit lands in `data_out[WIDTH-1]`; 0 = first bit lands in `data_out[0]`.

- `clk`  in  1: system clock, 100 MHz, rising edge active.
- `rst`  in  1: reset, synchronous, active-low.
- `serial_in`  in  1: serial data bit.
- `bit_valid`  in  1: `serial_in` is sampled only on cycles where this is 1.
- `frame_start`  in  1: qualified by `bit_valid`; the sampled bit is bit 0 of a new word.
- `data_out`  out  WIDTH: completed word, stable while `data_valid`=1.
- `data_valid`  out  1: `data_out` holds an undelivered word.
- `data_ready`  in  1: downstream accepts the word when `data_valid` and `data_ready` are both 1.
- `overflow`  out  1: sticky; a completed word was dropped.
- `ovf_clr`  in  1: clears `overflow`.
- `parity_err`  out  1: pulse, parity mismatch on the delivered word (see Configuration).

## Operation
- Internal shift register `sr[WIDTH-1:0]` and bit counter `cnt` (0..N-1), where N = WIDTH, or WIDTH+1 when parity is enabled.
- Shift rules when `bit_valid`=1:
  - MSB_FIRST: `sr <= {sr[WIDTH-2:0], serial_in}`.
  - LSB_FIRST: `sr <= {serial_in, sr[WIDTH-1:1]}`.
- Counter rules when `bit_valid`=1:
  - `frame_start`=1: `cnt <= 1`, and the sampled bit is the first bit of the new word. Any partial word is discarded silently.
  - Otherwise `cnt` increments and wraps N-1 -> 0.
- Word completion: `bit_valid`=1 with `cnt`=N-1 and `frame_start`=0, or with N=1 semantics n/a. The completed word is `sr` after the shift.
- Output register on completion:
  - If `data_valid`=0, or if `data_valid`=1 and `data_ready`=1 in the same cycle: load `data_out`, set `data_valid`=1.
  - Else, with the holder full and not ready: drop the new word, keep the old word, set `overflow`=1.
- Handshake: `data_valid` falls the cycle after a transfer unless a new word loads in the same cycle. `data_out` does not change while `data_valid`=1 and `data_ready`=0.
- `overflow` priority: a set in the same cycle as `ovf_clr` wins (stays 1).
- `bit_valid`=0: no state change in the shifter or counter. The output handshake continues.

## Timing
- Reset values (`rst`=0 at a rising edge): `sr`=0, `cnt`=0, `data_out`=0, `data_valid`=0, `overflow`=0, `parity_err`=0.
- Reset mid-word discards the partial word. Reset while `data_valid`=1 drops the held word without flagging overflow.
- Latency: `data_valid`/`data_out` are valid in the cycle after the edge that samples the last bit (1 cycle).
- Throughput: one word per N `bit_valid` cycles, back-to-back with no gap when `data_ready` is held 1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SIPO_PARITY_EN` defined:
  - N = WIDTH+1. The bit after the last data bit is an even-parity bit and is not shifted into `sr`.
  - `parity_err` pulses for 1 cycle, aligned with the load of `data_out`, when XOR(data bits, parity bit) = 1.
  - The word is still delivered.
- `SIPO_PARITY_EN` undefined: N = WIDTH, and `parity_err` is tied to 0.

## Structure
- Package `sipo_pkg`:
  - `CNT_W(width)` function returning $clog2(width+1).
  - `PARITY_EVEN` constant.
- Sub-module `sipo_shift_core`: shift register plus counter plus completion strobe (and parity accumulator when enabled).
- Top `sipo_deser` adds the output register, handshake and overflow logic.

## Test plan
- WIDTH=8, MSB_FIRST=1, `data_ready`=1. Send bits 1,0,1,0,0,1,0,1 on consecutive cycles with `frame_start` on the first -> `data_valid`=1 for exactly 1 cycle, `data_out`=0xA5, one cycle after the 8th sample.
- WIDTH=8, MSB_FIRST=0. Send bits 0,0,0,1,0,0,1,0 -> `data_out`=0x48.
- `data_ready`=0. Send two complete words 0x11 then 0x22 -> `data_out` stays 0x11, `overflow`=1. Assert `ovf_clr`=1 -> `overflow`=0 the next cycle.
- After 5 bits of a word, pulse `frame_start` and send 0x3C MSB-first -> a single word 0x3C is delivered. The partial word is never output.
- Assert `rst`=0 mid-word with `data_valid`=1 -> all outputs are 0 on the next cycle. A new full word afterwards decodes correctly.
- With `SIPO_PARITY_EN`: send 0xA5 then parity 1 -> `parity_err`=1 with `data_out`=0xA5. Send parity 0 -> `parity_err`=0.
